io_read_sequencer: RTL and testbench
====================================

# io_read_sequencer

Executes the I/O-port read requested by the read stage (`io_read`, `io_read_address`, `read_length_word`/`read_length_dword`) as one or two aligned 32-bit bus cycles on the I/O bus. It assembles the bytes, returns a right-aligned result and pulses `rd_io_ready`. It sits directly downstream of the read-stage command logic and upstream of the I/O bus bridge. A pipeline flush during an access completes the bus cycle but discards the result.

## Interface
- No parameters.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `io_read`  in  1  level request from the read stage; held until `rd_io_ready`.
- `io_read_address`  in  16  port address; sampled only on request acceptance.
- `read_length_word`  in  1  access is 2 bytes.
- `read_length_dword`  in  1  access is 4 bytes (wins over word); neither set means 1 byte.
- `rd_reset`  in  1  pipeline flush; kills the current request.
- `rd_io_ready`  out  1  one-cycle pulse: `io_read_data` is valid.
- `io_read_data`  out  32  result, right-aligned, unused upper bytes zero.
- `io_bus_read`  out  1  bus read request.
- `io_bus_address`  out  16  dword-aligned address, bits [1:0] = 0.
- `io_bus_byteenable`  out  4  active byte lanes.
- `io_bus_waitrequest`  in  1  bus stall; request is accepted in a cycle with `io_bus_read`=1 and this =0.
- `io_bus_readdata`  in  32  return data.
- `io_bus_readdatavalid`  in  1  return data strobe, one per accepted read.

## Operation
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE.
- IDLE: on `io_read`=1 and `rd_reset`=0, latch address, length and offset `o`=addr[1:0], then go to REQ1.
  - n = 1, 2 or 4 bytes; m = (2^n−1) << o, an 8-bit mask.
  - Split access when m[7:4] ≠ 0.
  - `io_bus_address` = {addr[15:2],2'b00}; `io_bus_byteenable` = m[3:0].
- REQ1: `io_bus_read`=1; `io_bus_address` and `io_bus_byteenable` held stable until accepted. Acceptance moves to WAIT1.
- WAIT1: on `io_bus_readdatavalid`, capture lo = `io_bus_readdata`. Go to REQ2 if split, else DONE.
- REQ2: address = first address + 4, 16-bit wrap (0xFFFC → 0x0000); byteenable = m[7:4]. Acceptance moves to WAIT2.
- WAIT2: on valid, capture hi, then go to DONE.
- DONE: `rd_io_ready`=1 for exactly one cycle, `io_read_data` = ({hi,lo} >> 8·o) masked to n bytes, then go to IDLE.
  - `io_read_data` holds its value until the next DONE.
- Flush:
  - `rd_reset`=1 in IDLE: the request is ignored.
  - In REQ1/REQ2 before acceptance: drop `io_bus_read`, go to IDLE.
  - In WAIT1/WAIT2, or in REQ with acceptance in the same cycle: set a `killed` flag and continue until the outstanding readdatavalid. A split access does not issue the second read. Go to IDLE with no `rd_io_ready` pulse and `io_read_data` unchanged.
  - In DONE: the pulse is suppressed.
- `io_bus_readdatavalid` outside WAIT1/WAIT2 is ignored.
- Reset: state IDLE; `rd_io_ready`, `io_bus_read`, `io_bus_address`, `io_bus_byteenable`, `io_read_data`, `killed` all 0. Reset mid-transaction abandons it; the bus bridge shares `rst`.

## Timing
- Request sampled in IDLE at cycle T.
  - T+1: `io_bus_read`=1.
  - Zero-wait bus with valid in the cycle after acceptance: valid at T+2, `rd_io_ready` at T+3.
  - Split access: `rd_io_ready` at T+5 at best.
- Each `io_bus_waitrequest` cycle and each valid-delay cycle adds one cycle.
- At most one read is outstanding on the bus.
- The cycle after DONE is IDLE; a held `io_read` there is treated as a new request. The read stage must have advanced on `rd_io_ready`, so back-to-back IN instructions cost no bubble beyond IDLE.

## Test plan
- Byte read, addr 0x0061, zero-wait, readdata 0xAABBCCDD.
  - Expect byteenable 0b0010, bus address 0x0060, then `io_read_data`=0x000000CC with `rd_io_ready` at T+3.
- Dword read at 0x03F9, split.
  - Bus cycles: 0x03F8 with be 0b1110 (data 0x44332211), then 0x03FC with be 0b0001 (data 0x88776655).
  - Expect result 0x55443322, ready at T+5.
- Word read at 0xFFFF.
  - Bus cycles: 0xFFFC with be 0b1000 (data 0x12xxxxxx), then 0x0000 with be 0b0001 (data 0xxxxxxx34).
  - Expect 0x00003412.
- Waitrequest held 3 cycles on REQ1.
  - Expect address and byteenable stable throughout, `io_bus_read` held, ready at T+6.
- `rd_reset` pulsed during WAIT1 of a split dword read.
  - Expect no second bus read, no `rd_io_ready`, `io_read_data` unchanged, IDLE after the valid.
- `rst` asserted in WAIT2.
  - Expect all outputs 0 next cycle.
  - Then a new byte read at 0x0080 completes normally.

Source files
------------

// File: rtl/io_read_sequencer.sv
// io_read_sequencer: performs an I/O-port read of 1, 2 or 4 bytes as one or
// two dword-aligned bus cycles. It reassembles the bytes into a right-aligned
// result and pulses rd_io_ready. A flush lets an accepted bus cycle finish but
// discards its data.
module io_read_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_read,
  input  logic [15:0] io_read_address,
  input  logic        read_length_word,
  input  logic        read_length_dword,
  input  logic        rd_reset,
  output logic        rd_io_ready,
  output logic [31:0] io_read_data,
  output logic        io_bus_read,
  output logic [15:0] io_bus_address,
  output logic [3:0]  io_bus_byteenable,
  input  logic        io_bus_waitrequest,
  input  logic [31:0] io_bus_readdata,
  input  logic        io_bus_readdatavalid
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_offset;
  logic [3:0]  r_len_mask;   // one bit per result byte
  logic        r_split;
  logic [3:0]  r_be_hi;      // byte lanes for the second bus cycle
  logic        r_killed;
  logic [31:0] r_lo;
  logic [31:0] r_hi;
  logic        r_ready;
  logic [31:0] r_read_data;
  logic        r_bus_read;
  logic [15:0] r_bus_address;
  logic [3:0]  r_bus_be;

  logic [3:0]  w_len_mask;
  logic [7:0]  w_mask8;
  logic        w_kill;
  logic [31:0] w_lo_src;
  logic [31:0] w_hi_src;
  logic [63:0] w_shifted;
  logic [31:0] w_data_mask;
  logic [31:0] w_result;

  // Byte-count mask for the incoming request; dword wins over word.
  // NOTE: w_len_mask gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_len_mask = 4'b0001;
    if (read_length_dword)     w_len_mask = 4'b1111;
    else if (read_length_word) w_len_mask = 4'b0011;
  end

  assign w_mask8 = {4'b0000, w_len_mask} << io_read_address[1:0];
  assign w_kill  = r_killed | rd_reset;

  // Assemble from the data arriving this cycle, so the result can be
  // registered on the same edge that captures the last bus word.
  assign w_lo_src    = (r_state == S_WAIT1) ? io_bus_readdata : r_lo;
  assign w_hi_src    = (r_state == S_WAIT2) ? io_bus_readdata : r_hi;
  assign w_shifted   = {w_hi_src, w_lo_src} >> {r_offset, 3'b000};
  assign w_data_mask = {{8{r_len_mask[3]}}, {8{r_len_mask[2]}},
                        {8{r_len_mask[1]}}, {8{r_len_mask[0]}}};
  assign w_result    = w_shifted[31:0] & w_data_mask;

  // Sequencer FSM: issues bus cycles, captures data and produces the result.
  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_offset      <= 2'b00;
      r_len_mask    <= 4'b0000;
      r_split       <= 1'b0;
      r_be_hi       <= 4'b0000;
      r_killed      <= 1'b0;
      r_lo          <= 32'h0;
      r_hi          <= 32'h0;
      r_ready       <= 1'b0;
      r_read_data   <= 32'h0;
      r_bus_read    <= 1'b0;
      r_bus_address <= 16'h0;
      r_bus_be      <= 4'b0000;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_read && !rd_reset) begin
            r_offset      <= io_read_address[1:0];
            r_len_mask    <= w_len_mask;
            r_split       <= |w_mask8[7:4];
            r_be_hi       <= w_mask8[7:4];
            r_killed      <= 1'b0;
            r_bus_address <= {io_read_address[15:2], 2'b00};
            r_bus_be      <= w_mask8[3:0];
            r_bus_read    <= 1'b1;
            r_state       <= S_REQ1;
          end
        end
        S_REQ1, S_REQ2: begin
          if (!io_bus_waitrequest) begin
            // Accepted: the read is outstanding, so a flush only marks it.
            r_bus_read <= 1'b0;
            if (rd_reset) r_killed <= 1'b1;
            r_state <= (r_state == S_REQ1) ? S_WAIT1 : S_WAIT2;
          end else if (rd_reset) begin
            r_bus_read <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_WAIT1: begin
          if (rd_reset) r_killed <= 1'b1;
          if (io_bus_readdatavalid) begin
            r_lo <= io_bus_readdata;
            if (w_kill) begin
              r_state <= S_IDLE;
            end else if (r_split) begin
              r_bus_address <= r_bus_address + 16'd4;   // wraps 0xFFFC -> 0x0000
              r_bus_be      <= r_be_hi;
              r_bus_read    <= 1'b1;
              r_state       <= S_REQ2;
            end else begin
              r_read_data <= w_result;
              r_ready     <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_WAIT2: begin
          if (rd_reset) r_killed <= 1'b1;
          if (io_bus_readdatavalid) begin
            r_hi <= io_bus_readdata;
            if (w_kill) begin
              r_state <= S_IDLE;
            end else begin
              r_read_data <= w_result;
              r_ready     <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A flush arriving in the DONE cycle suppresses the pulse.
  assign rd_io_ready       = r_ready & ~rd_reset;
  assign io_read_data      = r_read_data;
  assign io_bus_read       = r_bus_read;
  assign io_bus_address    = r_bus_address;
  assign io_bus_byteenable = r_bus_be;

endmodule

// File: tb/tb_io_read_sequencer.sv
// Directed bench for io_read_sequencer: a table of single reads served by a
// small in-bench bus responder, plus hand-written flush and reset sequences.
module tb_io_read_sequencer;

  logic        clk;
  logic        rst;
  logic        io_read;
  logic [15:0] io_read_address;
  logic        read_length_word;
  logic        read_length_dword;
  logic        rd_reset;
  logic        rd_io_ready;
  logic [31:0] io_read_data;
  logic        io_bus_read;
  logic [15:0] io_bus_address;
  logic [3:0]  io_bus_byteenable;
  logic        io_bus_waitrequest;
  logic [31:0] io_bus_readdata;
  logic        io_bus_readdatavalid;

  io_read_sequencer dut (
    .clk                  (clk),
    .rst                  (rst),
    .io_read              (io_read),
    .io_read_address      (io_read_address),
    .read_length_word     (read_length_word),
    .read_length_dword    (read_length_dword),
    .rd_reset             (rd_reset),
    .rd_io_ready          (rd_io_ready),
    .io_read_data         (io_read_data),
    .io_bus_read          (io_bus_read),
    .io_bus_address       (io_bus_address),
    .io_bus_byteenable    (io_bus_byteenable),
    .io_bus_waitrequest   (io_bus_waitrequest),
    .io_bus_readdata      (io_bus_readdata),
    .io_bus_readdatavalid (io_bus_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        word;
    logic        dword;
    logic [31:0] lo;      // data returned for the first bus cycle
    logic [31:0] hi;      // data returned for the second bus cycle
    int          wait1;   // waitrequest cycles on the first request
    int          vdly;    // extra cycles before each readdatavalid
    int          nreq;    // expected number of bus reads
    logic [15:0] a1;
    logic [3:0]  be1;
    logic [15:0] a2;
    logic [3:0]  be2;
    logic [31:0] data;    // expected io_read_data
    int          lat;     // expected cycles from request to rd_io_ready
  } vec_t;

  vec_t        vecs[9];
  int          n_cmp;
  int          n_fail;
  logic [31:0] exp_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to the middle of the next cycle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one read and play the bus; called and returning at a negedge.
  task automatic run_vec(input vec_t v, input int id);
    int          wait_left;
    int          vdly_left;
    int          nreq;
    bit          pend;
    bit          unstable;
    bit          done;
    int          lat;
    logic [31:0] data;
    logic [15:0] a_seen[2];
    logic [3:0]  be_seen[2];
    bit          seen[2];
    string       tag;
    tag = $sformatf("v%0d", id);
    wait_left = v.wait1; vdly_left = 0; nreq = 0; pend = 0;
    unstable = 0; done = 0; lat = 0; data = 32'h0;
    seen[0] = 0; seen[1] = 0;
    a_seen[0] = 16'h0; a_seen[1] = 16'h0; be_seen[0] = 4'h0; be_seen[1] = 4'h0;
    io_read           = 1'b1;
    io_read_address   = v.addr;
    read_length_word  = v.word;
    read_length_dword = v.dword;
    for (int k = 1; k <= 30 && !done; k++) begin
      step();
      io_bus_readdatavalid = 1'b0;
      if (pend) begin
        if (vdly_left == 0) begin
          io_bus_readdatavalid = 1'b1;
          io_bus_readdata      = (nreq == 1) ? v.lo : v.hi;
          pend = 0;
        end else begin
          vdly_left--;
        end
      end
      if (io_bus_read) begin
        if (nreq < 2) begin
          if (!seen[nreq]) begin
            seen[nreq]    = 1;
            a_seen[nreq]  = io_bus_address;
            be_seen[nreq] = io_bus_byteenable;
          end else if (a_seen[nreq] !== io_bus_address || be_seen[nreq] !== io_bus_byteenable) begin
            unstable = 1;
          end
        end
        if (wait_left > 0) begin
          io_bus_waitrequest = 1'b1;
          wait_left--;
        end else begin
          io_bus_waitrequest = 1'b0;
          pend = 1;
          vdly_left = v.vdly;
          nreq++;
        end
      end else begin
        io_bus_waitrequest = 1'b0;
      end
      if (rd_io_ready) begin
        lat  = k;
        data = io_read_data;
        done = 1;
        io_read = 1'b0;
      end
    end
    io_read = 1'b0;
    io_bus_readdatavalid = 1'b0;
    io_bus_waitrequest   = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: no rd_io_ready within 30 cycles", tag);
    end else begin
      check({tag, " latency"}, 32'(lat), 32'(v.lat));
      check({tag, " data"}, data, v.data);
      check({tag, " nreq"}, 32'(nreq), 32'(v.nreq));
      check({tag, " addr1"}, 32'(a_seen[0]), 32'(v.a1));
      check({tag, " be1"}, 32'(be_seen[0]), 32'(v.be1));
      check({tag, " stable"}, 32'(unstable), 32'd0);
      if (v.nreq == 2) begin
        check({tag, " addr2"}, 32'(a_seen[1]), 32'(v.a2));
        check({tag, " be2"}, 32'(be_seen[1]), 32'(v.be2));
      end
      step();
      check({tag, " pulse_1cyc"}, 32'(rd_io_ready), 32'd0);
      exp_last = v.data;
    end
  endtask

  initial begin
    int bus_reads;
    int readies;
    n_cmp = 0; n_fail = 0; exp_last = 32'h0;

    //                addr     w  d  lo            hi            wt dl nr a1       be1      a2       be2      data          lat
    vecs[0] = '{16'h0061, 0, 0, 32'hAABBCCDD, 32'h0,        0, 0, 1, 16'h0060, 4'b0010, 16'h0,   4'b0000, 32'h000000CC, 3};
    vecs[1] = '{16'h03F9, 0, 1, 32'h44332211, 32'h88776655, 0, 0, 2, 16'h03F8, 4'b1110, 16'h03FC, 4'b0001, 32'h55443322, 5};
    vecs[2] = '{16'hFFFF, 1, 0, 32'h12ABCDEF, 32'hDEADBE34, 0, 0, 2, 16'hFFFC, 4'b1000, 16'h0000, 4'b0001, 32'h00003412, 5};
    vecs[3] = '{16'h0102, 1, 0, 32'hCAFE1234, 32'h0,        3, 0, 1, 16'h0100, 4'b1100, 16'h0,   4'b0000, 32'h0000CAFE, 6};
    vecs[4] = '{16'h1234, 0, 1, 32'h01020304, 32'h0,        0, 2, 1, 16'h1234, 4'b1111, 16'h0,   4'b0000, 32'h01020304, 5};
    vecs[5] = '{16'h0003, 1, 0, 32'h7F000000, 32'h000000A5, 0, 0, 2, 16'h0000, 4'b1000, 16'h0004, 4'b0001, 32'h0000A57F, 5};
    vecs[6] = '{16'h0010, 1, 1, 32'h89ABCDEF, 32'h0,        0, 0, 1, 16'h0010, 4'b1111, 16'h0,   4'b0000, 32'h89ABCDEF, 3};
    vecs[7] = '{16'h0003, 0, 0, 32'hF0E1D2C3, 32'h0,        0, 0, 1, 16'h0000, 4'b1000, 16'h0,   4'b0000, 32'h000000F0, 3};
    vecs[8] = '{16'h0002, 0, 1, 32'hBBAA0000, 32'h0000DDCC, 1, 1, 2, 16'h0000, 4'b1100, 16'h0004, 4'b0011, 32'hDDCCBBAA, 8};

    rst = 1'b1; io_read = 1'b0; io_read_address = 16'h0; read_length_word = 1'b0;
    read_length_dword = 1'b0; rd_reset = 1'b0; io_bus_waitrequest = 1'b0;
    io_bus_readdata = 32'h0; io_bus_readdatavalid = 1'b0;
    @(negedge clk);
    step(); step();
    check("reset ready", 32'(rd_io_ready), 32'd0);
    check("reset bus_read", 32'(io_bus_read), 32'd0);
    check("reset address", 32'(io_bus_address), 32'd0);
    check("reset be", 32'(io_bus_byteenable), 32'd0);
    check("reset data", io_read_data, 32'd0);
    rst = 1'b0;

    // Flush held in IDLE: the request is ignored.
    io_read = 1'b1; io_read_address = 16'h0061; rd_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle flush no read", 32'(io_bus_read), 32'd0);
    end
    io_read = 1'b0; rd_reset = 1'b0;
    step();

    // Flush in REQ1 before acceptance drops the bus read.
    io_read = 1'b1; io_bus_waitrequest = 1'b1;
    step();
    check("req1 flush read issued", 32'(io_bus_read), 32'd1);
    rd_reset = 1'b1; io_read = 1'b0;
    step();
    check("req1 flush read dropped", 32'(io_bus_read), 32'd0);
    rd_reset = 1'b0; io_bus_waitrequest = 1'b0;
    step();
    check("req1 flush no ready", 32'(rd_io_ready), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Flush during WAIT1 of a split dword read.
    io_read = 1'b1; io_read_address = 16'h03F9; read_length_dword = 1'b1; read_length_word = 1'b0;
    step();                                   // REQ1, accepted this cycle
    check("kill req1 read", 32'(io_bus_read), 32'd1);
    step();                                   // WAIT1
    rd_reset = 1'b1; io_read = 1'b0;
    step();                                   // WAIT1, valid arrives
    rd_reset = 1'b0;
    io_bus_readdatavalid = 1'b1; io_bus_readdata = 32'h44332211;
    bus_reads = 0; readies = 0;
    for (int i = 0; i < 6; i++) begin
      if (io_bus_read) bus_reads++;
      if (rd_io_ready) readies++;
      step();
      io_bus_readdatavalid = 1'b0;
    end
    check("kill no second read", 32'(bus_reads), 32'd0);
    check("kill no ready", 32'(readies), 32'd0);
    check("kill data unchanged", io_read_data, exp_last);
    read_length_dword = 1'b0;
    run_vec(vecs[0], 100);                    // back in IDLE: normal latency

    // Reset asserted in WAIT2 of a split read.
    io_read = 1'b1; io_read_address = 16'h03F9; read_length_dword = 1'b1;
    step();                                   // REQ1
    step();                                   // WAIT1
    io_bus_readdatavalid = 1'b1; io_bus_readdata = 32'h44332211;
    step();                                   // REQ2
    io_bus_readdatavalid = 1'b0;
    check("rst req2 read", 32'(io_bus_read), 32'd1);
    check("rst req2 addr", 32'(io_bus_address), 32'h03FC);
    step();                                   // WAIT2
    rst = 1'b1;
    step();
    check("rst ready", 32'(rd_io_ready), 32'd0);
    check("rst bus_read", 32'(io_bus_read), 32'd0);
    check("rst address", 32'(io_bus_address), 32'd0);
    check("rst be", 32'(io_bus_byteenable), 32'd0);
    check("rst data", io_read_data, 32'd0);
    rst = 1'b0; io_read = 1'b0; read_length_dword = 1'b0;
    step();
    run_vec('{16'h0080, 0, 0, 32'h5A5A5AA5, 32'h0, 0, 0, 1, 16'h0080, 4'b0001,
              16'h0, 4'b0000, 32'h000000A5, 3}, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
